// File: rtl/handle_pkg.sv
// Shared definitions for the handle table: bus op codes, command codes,
// the controller state type and address-building helpers.
package handle_pkg;

    // Bus operation codes carried on i_op / o_op.
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;

    // Command codes; the meaning of each depends on READ vs WRITE.
    localparam logic [1:0] CMD_ALLOC_MAP   = 2'd0;  // READ: alloc      WRITE: map base
    localparam logic [1:0] CMD_LIMIT       = 2'd1;  // READ: query base WRITE: set limit
    localparam logic [1:0] CMD_FREE_QLIMIT = 2'd2;  // READ: query limit WRITE: free
    localparam logic [1:0] CMD_CLEAR_COUNT = 2'd3;  // READ: free count WRITE: clear all

    // Controller state: normal request servicing, or the clear-all sweep.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    // Builds a command-space address: flag set, handle id all-ones,
    // command in [hw+1:hw], target id in [hw-1:0].
    function automatic logic [31:0] cmd_addr(input int w, input int hw,
                                             input logic [1:0] cmd,
                                             input logic [7:0] target);
        logic [31:0] a;
        a = 32'd1 << (w - 1);
        a = a | (((32'd1 << hw) - 32'd1) << (w - hw - 1));
        a = a | (32'(cmd) << hw) | (32'(target) & ((32'd1 << hw) - 32'd1));
        return a;
    endfunction

    // Builds a translated-handle address: flag set, handle id, offset.
    function automatic logic [31:0] xlate_addr(input int w, input int hw,
                                               input logic [7:0] id,
                                               input logic [31:0] offset);
        logic [31:0] a;
        a = 32'd1 << (w - 1);
        a = a | ((32'(id) & ((32'd1 << hw) - 32'd1)) << (w - hw - 1));
        a = a | (offset & ((32'd1 << (w - hw - 1)) - 32'd1));
        return a;
    endfunction

endpackage

// File: rtl/handle_free_finder.sv
// Free-entry finder: lowest-index invalid entry, whether one exists,
// and how many entries are currently invalid.
module handle_free_finder
    import handle_pkg::*;
#(
    parameter int HW = 3
) (
    input  logic [(2**HW)-2:0] valid_i,
    output logic [HW-1:0]      first_free_o,
    output logic               found_o,
    output logic [HW-1:0]      free_count_o
);
    localparam int ENTRIES = (2 ** HW) - 1;

    logic [ENTRIES-1:0] free_vec;

    assign free_vec = ~valid_i;

    // Priority encoder: scanning downwards lets the lowest free index win.
    always_comb begin
        first_free_o = '0;
        found_o      = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                first_free_o = HW'(i);
                found_o      = 1'b1;
            end
        end
    end

    // Popcount of free entries; ENTRIES = 2^HW-1 always fits in HW bits.
    always_comb begin
        free_count_o = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            free_count_o = free_count_o + HW'(free_vec[i]);
        end
    end

endmodule

// File: rtl/handle_table.sv
// Handle table: translates handle addresses to physical addresses with
// bounds checking and services the handle-management command space.
// One request per cycle, registered responses one cycle later; a
// clear-all request sweeps every entry with the bus stalled.
module handle_table
    import handle_pkg::*;
#(
    parameter int W  = 16,
    parameter int HW = 3
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [2:0]    i_op,
    input  logic [W-1:0]  i_address,
    input  logic [W-1:0]  i_data,
    output logic          o_valid,
    output logic [2:0]    o_op,
    output logic [W-1:0]  o_address,
    output logic [W-1:0]  o_data,
    output logic          o_fault,
    output logic [HW-1:0] o_free_count
);
    localparam int              ENTRIES   = (2 ** HW) - 1;
    localparam int              OFFW      = W - HW - 1;
    localparam logic [HW-1:0]   ID_CMD    = {HW{1'b1}};
    localparam logic [OFFW-1:0] LIMIT_MAX = {OFFW{1'b1}};

    // Controller state
    state_e        state_q, state_d;
    logic [HW-1:0] idx_q, idx_d;

    // Registered response
    logic          o_valid_q, o_valid_d;
    logic [2:0]    o_op_q, o_op_d;
    logic [W-1:0]  o_address_q, o_address_d;
    logic [W-1:0]  o_data_q, o_data_d;
    logic          o_fault_q, o_fault_d;

    // Entry state gathered from the per-entry registers
    logic [ENTRIES-1:0] valid_vec;
    logic [W-1:0]       base_arr  [ENTRIES];
    logic [OFFW-1:0]    limit_arr [ENTRIES];

    // Free finder results
    logic [HW-1:0] first_free;
    logic          free_found;
    logic [HW-1:0] free_count;

    // Request decode
    logic            accept;
    logic            addr_flag;
    logic [HW-1:0]   addr_id;
    logic [OFFW-1:0] addr_offset;
    logic [1:0]      cmd_code;
    logic [HW-1:0]   cmd_target;
    logic            is_cmd;
    logic [HW-1:0]   lookup_idx;
    logic            target_ok;

    // Selected entry for the current request
    logic            lk_valid;
    logic [W-1:0]    lk_base;
    logic [OFFW-1:0] lk_limit;

    // Entry update strobes (qualified per entry by index below)
    logic alloc_we, map_we, limit_we, free_we, sweep_we;

    assign o_ready      = (state_q == IDLE);
    assign accept       = i_valid && o_ready && (i_op != OP_NOP);
    assign addr_flag    = i_address[W-1];
    assign addr_id      = i_address[W-2:OFFW];
    assign addr_offset  = i_address[OFFW-1:0];
    assign cmd_code     = i_address[HW+1:HW];
    assign cmd_target   = i_address[HW-1:0];
    assign is_cmd       = (addr_id == ID_CMD);
    // Translates look up the addressed handle, commands look up their target.
    assign lookup_idx   = is_cmd ? cmd_target : addr_id;
    assign target_ok    = (cmd_target != ID_CMD) && lk_valid;
    assign sweep_we     = (state_q == SWEEP);

    assign o_valid      = o_valid_q;
    assign o_op         = o_op_q;
    assign o_address    = o_address_q;
    assign o_data       = o_data_q;
    assign o_fault      = o_fault_q;
    assign o_free_count = free_count;

    handle_free_finder #(
        .HW (HW)
    ) u_free_finder (
        .valid_i      (valid_vec),
        .first_free_o (first_free),
        .found_o      (free_found),
        .free_count_o (free_count)
    );

    // Mux out the entry selected by the request (reserved id selects nothing).
    always_comb begin
        lk_valid = 1'b0;
        lk_base  = '0;
        lk_limit = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (lookup_idx == HW'(i)) begin
                lk_valid = valid_vec[i];
                lk_base  = base_arr[i];
                lk_limit = limit_arr[i];
            end
        end
    end

    // Next-state, response and entry-update decode for the current cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        o_valid_d   = 1'b0;
        o_op_d      = OP_NOP;
        o_address_d = '0;
        o_data_d    = '0;
        o_fault_d   = 1'b0;
        alloc_we    = 1'b0;
        map_we      = 1'b0;
        limit_we    = 1'b0;
        free_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    o_valid_d = 1'b1;
                    if (!addr_flag) begin
                        o_op_d      = i_op;
                        o_address_d = i_address;
                        o_data_d    = i_data;
                    end else if (!is_cmd) begin
                        // limit=0 faults every offset, including 0.
                        if (!lk_valid || (addr_offset >= lk_limit)) begin
                            o_fault_d = 1'b1;
                        end else begin
                            o_op_d      = i_op;
                            o_address_d = lk_base + W'(addr_offset);
                            o_data_d    = i_data;
                        end
                    end else if (i_op == OP_READ) begin
                        case (cmd_code)
                            CMD_ALLOC_MAP: begin
                                if (free_found) begin
                                    alloc_we = 1'b1;
                                    o_data_d = W'(first_free);
                                end else begin
                                    o_data_d  = W'(ID_CMD);
                                    o_fault_d = 1'b1;
                                end
                            end
                            CMD_LIMIT: begin
                                if (target_ok) o_data_d = lk_base;
                                else           o_fault_d = 1'b1;
                            end
                            CMD_FREE_QLIMIT: begin
                                if (target_ok) o_data_d = W'(lk_limit);
                                else           o_fault_d = 1'b1;
                            end
                            default: begin
                                o_data_d = W'(free_count);
                            end
                        endcase
                    end else if (i_op == OP_WRITE) begin
                        if (cmd_code == CMD_CLEAR_COUNT) begin
                            // The sweep's completion produces the response.
                            o_valid_d = 1'b0;
                            state_d   = SWEEP;
                            idx_d     = '0;
                        end else if (!target_ok) begin
                            o_fault_d = 1'b1;
                        end else begin
                            map_we   = (cmd_code == CMD_ALLOC_MAP);
                            limit_we = (cmd_code == CMD_LIMIT);
                            free_we  = (cmd_code == CMD_FREE_QLIMIT);
                        end
                    end else begin
                        // Undefined op codes have no command meaning.
                        o_fault_d = 1'b1;
                    end
                end
            end
            SWEEP: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == HW'(ENTRIES - 1)) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    o_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Controller state and registered response.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            o_valid_q   <= 1'b0;
            o_op_q      <= OP_NOP;
            o_address_q <= '0;
            o_data_q    <= '0;
            o_fault_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            o_valid_q   <= o_valid_d;
            o_op_q      <= o_op_d;
            o_address_q <= o_address_d;
            o_data_q    <= o_data_d;
            o_fault_q   <= o_fault_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic            ent_valid_q;
            logic [W-1:0]    ent_base_q;
            logic [OFFW-1:0] ent_limit_q;
            logic            ent_clr;
            logic            ent_alloc;
            logic            ent_map;
            logic            ent_lim;

            assign ent_clr   = (sweep_we && (idx_q == HW'(gi))) ||
                               (free_we && (cmd_target == HW'(gi)));
            assign ent_alloc = alloc_we && (first_free == HW'(gi));
            assign ent_map   = map_we && (cmd_target == HW'(gi));
            assign ent_lim   = limit_we && (cmd_target == HW'(gi));

            // One handle entry: clear beats alloc, alloc beats map/limit.
            always_ff @(posedge i_clock) begin
                if (!i_reset_n) begin
                    ent_valid_q <= 1'b0;
                    ent_base_q  <= '0;
                    ent_limit_q <= '0;
                end else if (ent_clr) begin
                    ent_valid_q <= 1'b0;
                    ent_base_q  <= '0;
                    ent_limit_q <= '0;
                end else if (ent_alloc) begin
                    ent_valid_q <= 1'b1;
                    ent_base_q  <= '0;
                    ent_limit_q <= LIMIT_MAX;
                end else begin
                    if (ent_map) ent_base_q  <= i_data;
                    if (ent_lim) ent_limit_q <= i_data[OFFW-1:0];
                end
            end

            assign valid_vec[gi] = ent_valid_q;
            assign base_arr[gi]  = ent_base_q;
            assign limit_arr[gi] = ent_limit_q;
        end
    endgenerate

endmodule
